fetcher_icache: RTL
===================

Name: fetcher_icache

Overview:
Instruction fetch stage with a small direct-mapped instruction cache. It sits directly upstream of the core scheduler: it consumes core_state and current_pc, and produces fetcher_state and instruction. On a hit the instruction returns in one cycle. On a miss it issues a read to program memory over a valid/ready channel, then fills the cache.

Parameters:
PROGRAM_MEM_ADDR_BITS, 8, width of the PC and the program memory address.
PROGRAM_MEM_DATA_BITS, 16, instruction width.
CACHE_LINES, 16, number of cache entries; power of 2, 2..64; one instruction per line.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
core_state  input  3  scheduler state: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
current_pc  input  PROGRAM_MEM_ADDR_BITS  PC to fetch; stable while core_state==FETCH.
flush  input  1  pulse; invalidates all cache lines (kernel reload).
mem_read_valid  output  1  program memory read request.
mem_read_address  output  PROGRAM_MEM_ADDR_BITS  request address.
mem_read_ready  input  1  single-cycle pulse; mem_read_data valid this cycle.
mem_read_data  input  PROGRAM_MEM_DATA_BITS  returned instruction.
fetcher_state  output  3  IDLE=0, FETCHING=1, FETCHED=2.
instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction; valid while fetcher_state==FETCHED.
hit_count  output  16  saturating count of cache hits.
miss_count  output  16  saturating count of cache misses.

Behaviour:
- Reset: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, hit_count=0, miss_count=0, all valid bits=0. Data and tag arrays are not reset. Reset mid-miss abandons the request; mem_read_valid drops on the next edge.
- Index = current_pc[log2(CACHE_LINES)-1:0]. Tag = the remaining upper PC bits. Hit = valid[index] && tag[index]==tag(current_pc).
- IDLE, core_state==FETCH, hit:
  - next edge: instruction<=data[index], fetcher_state<=FETCHED, hit_count increments.
  - FETCH to FETCHED latency is 1 cycle.
- IDLE, core_state==FETCH, miss:
  - next edge: fetcher_state<=FETCHING, mem_read_valid<=1, mem_read_address<=current_pc, miss_count increments.
- FETCHING:
  - mem_read_valid and mem_read_address are held until mem_read_ready.
  - On mem_read_ready: mem_read_valid<=0, instruction<=mem_read_data, fetcher_state<=FETCHED.
  - The same edge fills the line: data[index], tag[index] written, valid[index]<=1.
  - Miss latency = 1 + memory latency.
- FETCHED: hold instruction. When core_state==DECODE, return to IDLE on the next edge. Any other core_state keeps FETCHED.
- IDLE with core_state!=FETCH: no action, no counter change.
- mem_read_ready outside FETCHING is ignored.
- Flush:
  - Clears all valid bits on the next edge, in any fetcher state.
  - If flush coincides with a fill, flush wins: the line stays invalid, but the returned instruction is still delivered (FETCHED).
  - Flush coinciding with a hit lookup in IDLE: the lookup completes as a hit using pre-flush contents.
- Counters saturate at 16'hFFFF and are never cleared except by reset. Flush does not clear them.
- Conflict miss: a fill to an index overwrites tag and data unconditionally (direct-mapped, no write-back).
- Only one outstanding memory request at a time.

Test Plan:
- Cold miss: reset, core_state=FETCH, pc=0x05, memory returns 0x1234 after 3 cycles. Expect: mem_read_valid=1 with address 0x05 from cycle 1; FETCHED with instruction=0x1234 the cycle after ready; miss_count=1.
- Hit: repeat pc=0x05 after DECODE→IDLE. Expect: FETCHED with 0x1234 one cycle after FETCH, no mem_read_valid, hit_count=1.
- Conflict (CACHE_LINES=16): fetch 0x05, then 0x15 (data 0xABCD), then 0x05. Expect: three misses; the final fetch re-reads memory at 0x05.
- Flush during fill: pc=0x07 miss, assert flush on the same cycle as mem_read_ready (data 0x0F0F). Expect: instruction=0x0F0F, FETCHED; the next fetch of 0x07 misses.
- Reset mid-miss: reset while FETCHING. Expect: fetcher_state=0, mem_read_valid=0, counters 0 after the edge; a later fetch of a previously cached pc misses.
- Saturation: force 65,536 hits on pc=0x01. Expect: hit_count stays 0xFFFF and miss_count is unaffected.

Source files
------------

// File: rtl/fetcher_icache.sv
// Instruction fetch stage with a direct-mapped cache: a hit returns in 1 cycle, a miss in 1 + memory latency.
// One outstanding read at a time; the request stays asserted until the mem_read_ready pulse.
module fetcher_icache #(
  parameter int          PROGRAM_MEM_ADDR_BITS = 8,
  parameter int          PROGRAM_MEM_DATA_BITS = 16,
  parameter int          CACHE_LINES           = 16,
  parameter logic [15:0] COUNT_SAT             = 16'hFFFF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);

  localparam int IDX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  localparam logic [2:0] CORE_FETCH  = 3'd1;
  localparam logic [2:0] CORE_DECODE = 3'd2;

  typedef enum logic [2:0] {
    F_IDLE     = 3'd0,
    F_FETCHING = 3'd1,
    F_FETCHED  = 3'd2
  } fstate_t;

  fstate_t                          state_q, state_d;
  logic                             mem_vld_q, mem_vld_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
  logic [15:0]                      hit_cnt_q, hit_cnt_d;
  logic [15:0]                      miss_cnt_q, miss_cnt_d;
  logic [CACHE_LINES-1:0]           valid_q, valid_d;
  logic [TAG_BITS-1:0]              tag_q  [CACHE_LINES];
  logic [TAG_BITS-1:0]              tag_d  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] data_q [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] data_d [CACHE_LINES];

  logic [IDX_BITS-1:0] look_idx, fill_idx;
  logic [TAG_BITS-1:0] look_tag, fill_tag;
  logic                hit;

  assign look_idx = current_pc[IDX_BITS-1:0];
  assign look_tag = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
  // Fill uses the latched request address, since current_pc is only stable during FETCH.
  assign fill_idx = mem_addr_q[IDX_BITS-1:0];
  assign fill_tag = mem_addr_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
  assign hit      = valid_q[look_idx] && (tag_q[look_idx] == look_tag);

  always_comb begin
    state_d    = state_q;
    mem_vld_d  = mem_vld_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;

    case (state_q)
      F_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (hit) begin
            instr_d = data_q[look_idx];
            state_d = F_FETCHED;
            if (hit_cnt_q < COUNT_SAT) hit_cnt_d = hit_cnt_q + 16'd1;
          end else begin
            state_d    = F_FETCHING;
            mem_vld_d  = 1'b1;
            mem_addr_d = current_pc;
            if (miss_cnt_q < COUNT_SAT) miss_cnt_d = miss_cnt_q + 16'd1;
          end
        end
      end
      F_FETCHING: begin
        if (mem_read_ready) begin
          mem_vld_d         = 1'b0;
          instr_d           = mem_read_data;
          state_d           = F_FETCHED;
          data_d[fill_idx]  = mem_read_data;
          tag_d[fill_idx]   = fill_tag;
          valid_d[fill_idx] = 1'b1;
        end
      end
      F_FETCHED: begin
        if (core_state == CORE_DECODE) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase

    // Flush overrides a same-cycle fill; the fetched word is still delivered.
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= F_IDLE;
      mem_vld_q  <= 1'b0;
      mem_addr_q <= '0;
      instr_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_vld_q  <= mem_vld_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign fetcher_state    = state_q;
  assign mem_read_valid   = mem_vld_q;
  assign mem_read_address = mem_addr_q;
  assign instruction      = instr_q;
  assign hit_count        = hit_cnt_q;
  assign miss_count       = miss_cnt_q;

endmodule
